gate_edge_counter: RTL and testbench
====================================

GATE_EDGE_COUNTER -- requirements
Module: gate_edge_counter

Interface
REQ-001 SHALL have parameter WINDOW, default 500, meaning gate length in clk cycles; legal range WINDOW >= 2.
REQ-002 SHALL have derived localparam CNT_W = $clog2(WINDOW+1), the width of the count output.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock.
REQ-004 SHALL have reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have sig  input  1  raw asynchronous signal under measurement.
REQ-006 SHALL have enable  input  1  synchronous run request; 1 = measure continuously.
REQ-007 SHALL have count  output  CNT_W  number of sig transitions (both edges) in the last completed window.
REQ-008 SHALL have count_valid  output  1  one-cycle pulse marking a new count value.
REQ-009 SHALL have busy  output  1  high whenever state is not IDLE.

Function
REQ-010 SHALL pass sig through a 2-flop synchronizer (s1, s2), then one history flop s3; edge = s2 XOR s3.
REQ-011 SHALL implement states IDLE, PRIME, COUNT.
REQ-012 IDLE: stays while enable=0; enable=1 -> PRIME next cycle.
REQ-013 PRIME: lasts exactly 2 cycles, discards edge, clears accumulator and window counter, then -> COUNT.
REQ-014 COUNT: each cycle acc <= acc + edge, win <= win + 1; COUNT lasts exactly WINDOW cycles per window.
REQ-015 On the WINDOW-th COUNT cycle, count SHALL load acc + edge and count_valid SHALL be 1 in the following cycle only.
REQ-016 After window end with enable=1, the next window SHALL start on the very next cycle in COUNT (no PRIME, no gap); acc restarts at 0.
REQ-017 An edge on the last cycle of window n SHALL count in window n only; an edge on the first cycle of window n+1 counts in n+1.
REQ-018 After window end with enable=0, state SHALL return to IDLE; count_valid still pulses for the completed window.
REQ-019 enable=0 in PRIME or before the last COUNT cycle SHALL abort: -> IDLE next cycle, acc and win cleared, count unchanged, no count_valid.
REQ-020 acc SHALL be CNT_W bits wide and cannot overflow, since max edges per window = WINDOW.
REQ-021 count SHALL hold its value between count_valid pulses and across aborts.
REQ-022 busy SHALL be combinationally derived from state (state != IDLE).
REQ-023 Synchronizer flops SHALL run in all states, including IDLE.

Reset
REQ-024 reset_n=0 SHALL immediately (asynchronously) force state IDLE, and set s1, s2, s3, acc, win, count to 0, count_valid to 0 and busy to 0.
REQ-025 Reset assertion mid-window SHALL discard the partial window; no count_valid is issued.
REQ-026 After reset release, the block SHALL start in IDLE and require enable=1 to begin PRIME.

Verification
REQ-027 Directed scenario: WINDOW=10, enable held 1, sig toggling every clk -> count=10 with count_valid every 10 cycles, first pulse 13 cycles after the enable-sampled edge (2 PRIME + 10 COUNT + 1).
REQ-028 Directed scenario: WINDOW=10, sig held 1 from reset release, enable raised 5 cycles later -> every count=0.
REQ-029 Directed scenario: WINDOW=10, sig high for 3 cycles within COUNT cycles 3-7 of a window -> count=2 for that window.
REQ-030 Directed scenario: WINDOW=10, window 1 completes with count=4, then enable dropped at COUNT cycle 5 of window 2 -> no count_valid, count stays 4, busy=0 the next cycle.
REQ-031 Directed scenario: WINDOW=10, synchronized edge timed on the 10th COUNT cycle only -> window n count=1, window n+1 count=0.
REQ-032 Directed scenario: reset_n pulsed low at COUNT cycle 6 with acc=3 -> outputs 0 within the same cycle; after release and enable=1, the first count reflects only new edges.

Source files
------------

// File: rtl/gate_edge_counter.sv
// Gated edge counter: counts both edges of a synchronized input over fixed
// windows of WINDOW clock cycles and publishes each completed window's total.
module gate_edge_counter #(
  parameter int unsigned WINDOW = 500,
  localparam int unsigned CNT_W = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sig,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    COUNT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);

  state_t           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic             prime_q, prime_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             sig_edge;

  // Synchronizer and history flop run in every state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign sig_edge = s2_q ^ s3_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      prime_q <= 1'b0;
      acc_q   <= '0;
      win_q   <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prime_q <= prime_d;
      acc_q   <= acc_d;
      win_q   <= win_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prime_d = prime_q;
    acc_d   = acc_q;
    win_d   = win_q;
    count_d = count_q;
    valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        prime_d = 1'b0;
        acc_d   = '0;
        win_d   = '0;
        if (enable) state_d = PRIME;
      end
      PRIME: begin
        acc_d = '0;
        win_d = '0;
        if (!enable) begin
          state_d = IDLE;
          prime_d = 1'b0;
        end else if (prime_q) begin
          state_d = COUNT;
          prime_d = 1'b0;
        end else begin
          prime_d = 1'b1;
        end
      end
      COUNT: begin
        // The last window cycle always completes, even if enable just fell.
        if (win_q == WIN_LAST) begin
          count_d = acc_q + CNT_W'(sig_edge);
          valid_d = 1'b1;
          acc_d   = '0;
          win_d   = '0;
          state_d = enable ? COUNT : IDLE;
        end else if (!enable) begin
          state_d = IDLE;
          acc_d   = '0;
          win_d   = '0;
        end else begin
          acc_d = acc_q + CNT_W'(sig_edge);
          win_d = win_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign count       = count_q;
  assign count_valid = valid_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_gate_edge_counter.sv
// Bench for gate_edge_counter (WINDOW=10): directed scenarios plus random
// stimulus compared against a window-position reference model.
module tb_gate_edge_counter;

  localparam int unsigned W     = 10;
  localparam int unsigned CNT_W = $clog2(W + 1);

  logic             clk;
  logic             reset_n;
  logic             sig;
  logic             enable;
  logic [CNT_W-1:0] count;
  logic             count_valid;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  gate_edge_counter #(.WINDOW(W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sig         (sig),
    .enable      (enable),
    .count       (count),
    .count_valid (count_valid),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: position within the run and a running edge sum.
  // Edge seen at a rising edge t is sig(t-2) xor sig(t-3).
  bit m_run;
  int m_pos;
  int m_sum;
  int m_count;
  bit m_valid;
  bit p1, p2, p3;
  bit m_e, m_last;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_run = 0; m_pos = 0; m_sum = 0; m_count = 0; m_valid = 0;
      p1 = 0; p2 = 0; p3 = 0;
    end else begin
      m_e     = p2 ^ p3;
      m_valid = 0;
      if (!m_run) begin
        if (enable) begin
          m_run = 1; m_pos = 0; m_sum = 0;
        end
      end else begin
        m_last = (m_pos >= 2) && (((m_pos - 2) % W) == W - 1);
        if (!enable && !m_last) begin
          m_run = 0; m_sum = 0;
        end else begin
          if (m_pos >= 2) m_sum += int'(m_e);
          if (m_last) begin
            m_count = m_sum; m_valid = 1; m_sum = 0;
            if (!enable) m_run = 0;
          end
          m_pos++;
        end
      end
      p3 = p2; p2 = p1; p1 = sig;
    end
  end

  task automatic do_reset(input logic sig_val);
    enable  = 1'b0;
    sig     = sig_val;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    enable  = 1'b1;
    sig     = 1'b1;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (count !== '0 || count_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: count=%0d valid=%b busy=%b, need 0/0/0", count, count_valid, busy);
    end
    enable = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || count_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle_hold: busy=%b valid=%b at cycle %0d, need 0/0", busy, count_valid, i);
      end
    end
    enable = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_start_prime: busy=%b, need 1", busy);
    end
    enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_continuous_toggle;
    logic exp_v;
    do_reset(1'b0);
    repeat (4) begin
      sig = ~sig;
      @(negedge clk);
    end
    enable = 1'b1;
    sig    = ~sig;
    @(posedge clk);
    for (int n = 0; n < 35; n++) begin
      @(negedge clk);
      exp_v = (n == 12 || n == 22 || n == 32);
      n_checks++;
      if (count_valid !== exp_v || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL toggle_valid: n=%0d valid=%b busy=%b, need %b/1", n, count_valid, busy, exp_v);
      end
      if (exp_v) begin
        n_checks++;
        if (count !== CNT_W'(10)) begin
          n_fail++;
          $display("FAIL toggle_count: n=%0d count=%0d, need 10", n, count);
        end
      end
      sig = ~sig;
    end
  endtask

  task automatic test_sig_held;
    int pulses;
    pulses = 0;
    do_reset(1'b1);
    repeat (3) @(negedge clk);
    enable = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (count_valid === 1'b1) begin
        pulses++;
        n_checks++;
        if (count !== '0) begin
          n_fail++;
          $display("FAIL held_count: count=%0d, need 0", count);
        end
      end
    end
    n_checks++;
    if (pulses != 3) begin
      n_fail++;
      $display("FAIL held_pulses: saw %0d pulses, need 3", pulses);
    end
  endtask

  task automatic test_pulse;
    do_reset(1'b0);
    enable = 1'b1;
    @(posedge clk);
    for (int n = 0; n <= 12; n++) begin
      @(negedge clk);
      if (n == 3) sig = 1'b1;
      if (n == 6) sig = 1'b0;
    end
    n_checks++;
    if (count_valid !== 1'b1 || count !== CNT_W'(2)) begin
      n_fail++;
      $display("FAIL pulse_count: valid=%b count=%0d, need 1/2", count_valid, count);
    end
  endtask

  task automatic test_abort;
    do_reset(1'b0);
    enable = 1'b1;
    @(posedge clk);
    for (int n = 0; n <= 30; n++) begin
      @(negedge clk);
      if (n == 12) begin
        n_checks++;
        if (count_valid !== 1'b1 || count !== CNT_W'(4)) begin
          n_fail++;
          $display("FAIL abort_w1: valid=%b count=%0d, need 1/4", count_valid, count);
        end
      end
      if (n >= 13 && n <= 16) begin
        n_checks++;
        if (busy !== 1'b1 || count_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL abort_w2_run: n=%0d busy=%b valid=%b, need 1/0", n, busy, count_valid);
        end
      end
      if (n >= 17) begin
        n_checks++;
        if (busy !== 1'b0 || count_valid !== 1'b0 || count !== CNT_W'(4)) begin
          n_fail++;
          $display("FAIL abort_after: n=%0d busy=%b valid=%b count=%0d, need 0/0/4", n, busy, count_valid, count);
        end
      end
      if (n == 3 || n == 7) sig = 1'b1;
      if (n == 5 || n == 9) sig = 1'b0;
      if (n == 16) enable = 1'b0;
    end
  endtask

  task automatic test_last_cycle_edge;
    do_reset(1'b0);
    enable = 1'b1;
    @(posedge clk);
    for (int n = 0; n <= 22; n++) begin
      @(negedge clk);
      if (n == 12) begin
        n_checks++;
        if (count_valid !== 1'b1 || count !== CNT_W'(1)) begin
          n_fail++;
          $display("FAIL last_edge_w1: valid=%b count=%0d, need 1/1", count_valid, count);
        end
      end
      if (n == 22) begin
        n_checks++;
        if (count_valid !== 1'b1 || count !== '0) begin
          n_fail++;
          $display("FAIL last_edge_w2: valid=%b count=%0d, need 1/0", count_valid, count);
        end
      end
      if (n == 9) sig = 1'b1;
    end
  endtask

  task automatic test_reset_mid_window;
    do_reset(1'b0);
    repeat (4) begin
      sig = ~sig;
      @(negedge clk);
    end
    enable = 1'b1;
    sig    = ~sig;
    @(posedge clk);
    for (int n = 0; n <= 17; n++) begin
      @(negedge clk);
      if (n == 12) begin
        n_checks++;
        if (count !== CNT_W'(10)) begin
          n_fail++;
          $display("FAIL rstmid_w1: count=%0d, need 10", count);
        end
      end
      if (n <= 12) sig = ~sig;
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (count !== '0 || count_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_async: count=%0d valid=%b busy=%b, need 0/0/0", count, count_valid, busy);
    end
    enable = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    @(posedge clk);
    for (int n = 0; n <= 12; n++) begin
      @(negedge clk);
      if (n < 12) begin
        n_checks++;
        if (count_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL rstmid_early_valid: n=%0d valid=%b, need 0", n, count_valid);
        end
      end
      if (n == 3 || n == 6) sig = ~sig;
    end
    n_checks++;
    if (count_valid !== 1'b1 || count !== CNT_W'(2)) begin
      n_fail++;
      $display("FAIL rstmid_new: valid=%b count=%0d, need 1/2", count_valid, count);
    end
  endtask

  task automatic test_random;
    bit rst_release;
    int bias;
    rst_release = 0;
    do_reset(1'b0);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      n_checks++;
      if (count !== CNT_W'(m_count) || count_valid !== m_valid || busy !== m_run) begin
        n_fail++;
        $display("FAIL random_cycle: i=%0d count=%0d valid=%b busy=%b, need %0d/%b/%b",
                 i, count, count_valid, busy, m_count, m_valid, m_run);
      end
      if (rst_release) begin
        reset_n     = 1'b1;
        rst_release = 0;
      end
      if ($urandom_range(0, 99) < 3) enable = ~enable;
      bias = (i / 500) % 3;
      if (bias == 0)      sig = 1'($urandom_range(0, 1));
      else if (bias == 1) sig = ($urandom_range(0, 9) == 0) ? ~sig : sig;
      else                sig = ($urandom_range(0, 3) != 0) ? ~sig : sig;
      if ($urandom_range(0, 399) == 0) begin
        #2 reset_n = 1'b0;
        rst_release = 1;
      end
    end
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    sig     = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_continuous_toggle();
    test_sig_held();
    test_pulse();
    test_abort();
    test_last_cycle_edge();
    test_reset_mid_window();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
